time_counter: RTL and testbench

- Keeps the alarm clock's current time of day as four BCD digits (HH:MM, 24-hour).
- Sits directly upstream of the LCD display/alarm-compare stage and drives its current-time digit inputs.
- Advances on a one-minute tick from the time generator.
- Accepts a parallel load of a user-entered time from the control FSM.

---
 rtl/alarm_clock_pkg.sv | 28 ++
 rtl/time_incr.sv | 35 +++
 rtl/time_counter.sv | 73 +++++++
 tb/tb_time_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock types: BCD digits, HH:MM time bundle and validity check.
package alarm_clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t ms_hr;
        bcd_digit_t ls_hr;
        bcd_digit_t ms_min;
        bcd_digit_t ls_min;
    } time_hhmm_t;

    localparam bcd_digit_t MAX_MS_HR       = 4'd2;
    localparam bcd_digit_t MAX_LS_HR_AT_20 = 4'd3;
    localparam bcd_digit_t MAX_MS_MIN      = 4'd5;
    localparam bcd_digit_t MAX_BCD         = 4'd9;
    localparam time_hhmm_t MIDNIGHT        = '0;

    function automatic logic is_valid_time(input time_hhmm_t t);
        logic ok;
        ok = (t.ms_hr <= MAX_MS_HR) && (t.ls_hr <= MAX_BCD) &&
             (t.ms_min <= MAX_MS_MIN) && (t.ls_min <= MAX_BCD);
        if (t.ms_hr == MAX_MS_HR && t.ls_hr > MAX_LS_HR_AT_20)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/time_incr.sv
// Combinational next-minute function on a valid HH:MM BCD time.
module time_incr
    import alarm_clock_pkg::*;
(
    input  time_hhmm_t cur,
    output time_hhmm_t next,
    output logic       wrap
);

    always_comb begin
        next = cur;
        wrap = 1'b0;
        if (cur.ls_min != MAX_BCD) begin
            next.ls_min = cur.ls_min + 4'd1;
        end else begin
            next.ls_min = 4'd0;
            if (cur.ms_min != MAX_MS_MIN) begin
                next.ms_min = cur.ms_min + 4'd1;
            end else begin
                next.ms_min = 4'd0;
                // 23:59 is the only hour value that wraps the whole day
                if (cur.ms_hr == MAX_MS_HR && cur.ls_hr == MAX_LS_HR_AT_20) begin
                    next = MIDNIGHT;
                    wrap = 1'b1;
                end else if (cur.ls_hr == MAX_BCD) begin
                    next.ls_hr = 4'd0;
                    next.ms_hr = cur.ms_hr + 4'd1;
                end else begin
                    next.ls_hr = cur.ls_hr + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/time_counter.sv
// Current time-of-day register: minute ticks, validated parallel load.
module time_counter
    import alarm_clock_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       load_reject,
    output logic       day_rollover
);

    time_hhmm_t cur_q;
    time_hhmm_t cur_d;
    time_hhmm_t load_val;
    time_hhmm_t inc_val;
    logic       inc_wrap;
    logic       reject_d;
    logic       roll_d;

    assign load_val = '{ms_hr:  new_current_time_ms_hr,
                        ls_hr:  new_current_time_ls_hr,
                        ms_min: new_current_time_ms_min,
                        ls_min: new_current_time_ls_min};

    time_incr u_incr (
        .cur  (cur_q),
        .next (inc_val),
        .wrap (inc_wrap)
    );

    // A valid load pre-empts a coincident tick; an invalid one lets it through
    always_comb begin
        cur_d    = cur_q;
        reject_d = 1'b0;
        roll_d   = 1'b0;
        if (load_new_c && is_valid_time(load_val)) begin
            cur_d = load_val;
        end else begin
            reject_d = load_new_c;
            if (one_minute) begin
                cur_d  = inc_val;
                roll_d = inc_wrap;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_q        <= MIDNIGHT;
            load_reject  <= 1'b0;
            day_rollover <= 1'b0;
        end else begin
            cur_q        <= cur_d;
            load_reject  <= reject_d;
            day_rollover <= roll_d;
        end
    end

    assign current_time_ms_hr  = cur_q.ms_hr;
    assign current_time_ls_hr  = cur_q.ls_hr;
    assign current_time_ms_min = cur_q.ms_min;
    assign current_time_ls_min = cur_q.ls_min;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter using a minutes-of-day model.
module tb_time_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_minute = 1'b0;
    logic       load_new_c = 1'b0;
    logic [3:0] n_ms_hr = 4'd0;
    logic [3:0] n_ls_hr = 4'd0;
    logic [3:0] n_ms_min = 4'd0;
    logic [3:0] n_ls_min = 4'd0;
    logic [3:0] c_ms_hr;
    logic [3:0] c_ls_hr;
    logic [3:0] c_ms_min;
    logic [3:0] c_ls_min;
    logic       load_reject;
    logic       day_rollover;

    int asserts = 0;
    int fails = 0;
    bit run = 1'b0;

    int exp_m = 0;
    bit exp_rej = 1'b0;
    bit exp_roll = 1'b0;

    time_counter dut (
        .clock                   (clock),
        .reset                   (reset),
        .one_minute              (one_minute),
        .load_new_c              (load_new_c),
        .new_current_time_ms_hr  (n_ms_hr),
        .new_current_time_ls_hr  (n_ls_hr),
        .new_current_time_ms_min (n_ms_min),
        .new_current_time_ls_min (n_ls_min),
        .current_time_ms_hr      (c_ms_hr),
        .current_time_ls_hr      (c_ls_hr),
        .current_time_ms_min     (c_ms_min),
        .current_time_ls_min     (c_ls_min),
        .load_reject             (load_reject),
        .day_rollover            (day_rollover)
    );

    always #5 clock = ~clock;

    function automatic bit digits_ok(input logic [15:0] v);
        int h;
        int m;
        if (v[15:12] > 9 || v[11:8] > 9 || v[7:4] > 9 || v[3:0] > 9)
            return 1'b0;
        h = int'(v[15:12]) * 10 + int'(v[11:8]);
        m = int'(v[7:4]) * 10 + int'(v[3:0]);
        return (h < 24) && (m < 60);
    endfunction

    function automatic logic [15:0] to_digits(input int mins);
        int h;
        int m;
        logic [15:0] r;
        h = mins / 60;
        m = mins % 60;
        r[15:12] = 4'(h / 10);
        r[11:8]  = 4'(h % 10);
        r[7:4]   = 4'(m / 10);
        r[3:0]   = 4'(m % 10);
        return r;
    endfunction

    function automatic logic [15:0] dut_time();
        return {c_ms_hr, c_ls_hr, c_ms_min, c_ls_min};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: time as minutes since midnight
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_m = 0;
            exp_rej = 1'b0;
            exp_roll = 1'b0;
        end else begin
            exp_rej = 1'b0;
            exp_roll = 1'b0;
            if (load_new_c && digits_ok({n_ms_hr, n_ls_hr, n_ms_min, n_ls_min})) begin
                exp_m = (int'(n_ms_hr) * 10 + int'(n_ls_hr)) * 60 +
                        int'(n_ms_min) * 10 + int'(n_ls_min);
            end else begin
                exp_rej = load_new_c;
                if (one_minute) begin
                    exp_roll = (exp_m == 1439);
                    exp_m = (exp_m + 1) % 1440;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (run) begin
            chk("model_time", 32'(dut_time()), 32'(to_digits(exp_m)));
            chk("model_reject", 32'(load_reject), 32'(exp_rej));
            chk("model_rollover", 32'(day_rollover), 32'(exp_roll));
        end
    end

    task automatic cyc(input bit ld, input logic [15:0] v, input bit tick);
        load_new_c = ld;
        {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min} = v;
        one_minute = tick;
        @(posedge clock);
        #1;
        load_new_c = 1'b0;
        one_minute = 1'b0;
    endtask

    task automatic expect_now(input string name, input logic [15:0] t,
                              input bit rej, input bit roll);
        @(negedge clock);
        chk({name, "_time"}, 32'(dut_time()), 32'(t));
        chk({name, "_rej"}, 32'(load_reject), 32'(rej));
        chk({name, "_roll"}, 32'(day_rollover), 32'(roll));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rolls;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        run = 1'b1;
        expect_now("reset_state", 16'h0000, 1'b0, 1'b0);

        cyc(1, 16'h0959, 0); cyc(0, 16'h0, 1);
        expect_now("carry_0959", 16'h1000, 1'b0, 1'b0);
        cyc(1, 16'h1959, 0); cyc(0, 16'h0, 1);
        expect_now("carry_1959", 16'h2000, 1'b0, 1'b0);
        cyc(1, 16'h1209, 0); cyc(0, 16'h0, 1);
        expect_now("carry_1209", 16'h1210, 1'b0, 1'b0);

        cyc(1, 16'h2359, 0); cyc(0, 16'h0, 1);
        expect_now("midnight", 16'h0000, 1'b0, 1'b1);
        expect_now("midnight_hold", 16'h0000, 1'b0, 1'b0);
        cyc(0, 16'h0, 1);
        expect_now("after_midnight", 16'h0001, 1'b0, 1'b0);

        cyc(1, 16'h0715, 0);
        cyc(1, 16'h2400, 0);
        expect_now("bad_2400", 16'h0715, 1'b1, 1'b0);
        expect_now("bad_2400_clr", 16'h0715, 1'b0, 1'b0);
        cyc(1, 16'h1260, 0);
        expect_now("bad_1260", 16'h0715, 1'b1, 1'b0);
        cyc(1, 16'h071A, 0);
        expect_now("bad_071A", 16'h0715, 1'b1, 1'b0);

        cyc(1, 16'h0830, 1);
        expect_now("load_wins", 16'h0830, 1'b0, 1'b0);
        cyc(1, 16'h2500, 1);
        expect_now("bad_with_tick", 16'h0831, 1'b1, 1'b0);

        cyc(1, 16'h2359, 0);
        cyc(1, 16'h3000, 1);
        expect_now("bad_at_2359", 16'h0000, 1'b1, 1'b1);

        cyc(1, 16'h1234, 0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_time", 32'(dut_time()), 32'h0000);
        chk("async_reset_rej", 32'(load_reject), 32'h0);
        chk("async_reset_roll", 32'(day_rollover), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        rolls = 0;
        @(negedge clock);
        one_minute = 1'b1;
        for (int i = 0; i < 1440; i++) begin
            @(negedge clock);
            if (day_rollover) rolls++;
            chk("day_valid", 32'(digits_ok(dut_time())), 32'h1);
        end
        one_minute = 1'b0;
        chk("day_time", 32'(dut_time()), 32'h0000);
        chk("day_rollovers", 32'(rolls), 32'd1);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
